// File: rtl/opcode_sequencer_pkg.sv
// Shared processor definitions: opcode encodings used by the sequencer and the
// control unit, the sequencer state encoding, and a small opcode classifier.
package opcode_sequencer_pkg;

  // Opcode encodings (instruction bits [15:11]).
  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_CALL  = 5'b11000;
  localparam logic [4:0] OP_CALL2 = 5'b11001;
  localparam logic [4:0] OP_RET   = 5'b11010;
  localparam logic [4:0] OP_RET2  = 5'b11011;
  localparam logic [4:0] OP_RTI   = 5'b11100;
  localparam logic [4:0] OP_RTI2  = 5'b11101;
  localparam logic [4:0] OP_INT1  = 5'b11110;
  localparam logic [4:0] OP_INT2  = 5'b11111;

  // Sequencer states. NORMAL is zero so reset and the all-zero state agree.
  localparam logic [2:0] ST_NORMAL = 3'd0;
  localparam logic [2:0] ST_CALL2  = 3'd1;
  localparam logic [2:0] ST_RET2   = 3'd2;
  localparam logic [2:0] ST_RTI2   = 3'd3;
  localparam logic [2:0] ST_INT2   = 3'd4;

  // Second-half and interrupt opcodes are generated internally only; seeing
  // one in the fetch stream means the program is malformed.
  function automatic logic is_internal_op(input logic [4:0] op);
    return (op == OP_CALL2) || (op == OP_RET2) || (op == OP_RTI2) ||
           (op == OP_INT1)  || (op == OP_INT2);
  endfunction

endpackage

// File: rtl/opcode_sequencer.sv
// Opcode sequencer: sits between fetch and the control unit. Splits CALL, RET
// and RTI into two issued opcodes, injects the two-cycle interrupt entry
// sequence, and turns hazards and flushes into bubbles / NOPs. All outputs
// except freezePC are registered (one cycle latency).
module opcode_sequencer
  import opcode_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] fetchedInstr,
  input  logic        fetchedValid,
  input  logic        interrupt,
  input  logic        stall,
  input  logic        flush,
  output logic [4:0]  opCode,
  output logic        makeMeBubble,
  output logic [10:0] instrOut,
  output logic        freezePC
);

  logic [2:0]  r_state;
  logic        r_int_pending;
  logic [10:0] r_saved;
  logic [4:0]  r_op_code;
  logic        r_bubble;
  logic [10:0] r_instr;

  logic [2:0]  w_next_state;
  logic [10:0] w_next_saved;
  logic [4:0]  w_next_op;
  logic        w_next_bubble;
  logic [10:0] w_next_instr;
  logic        w_clear_int;
  logic        w_freeze;
  logic [4:0]  w_fetched_op;
  logic [10:0] w_fetched_fields;

  assign w_fetched_op     = fetchedInstr[15:11];
  assign w_fetched_fields = fetchedInstr[10:0];

  // Decide this cycle's issued opcode and next state; priority is
  // flush > stall > second-half state > pending interrupt > fetched word.
  always_comb begin
    // NOTE: every signal gets a default before the priority chain so that no
    // path leaves one unassigned, which would otherwise infer a latch.
    w_next_state  = r_state;
    w_next_saved  = r_saved;
    w_next_op     = OP_NOP;
    w_next_bubble = 1'b0;
    w_next_instr  = 11'd0;
    w_clear_int   = 1'b0;
    w_freeze      = 1'b0;

    if (flush) begin
      // Younger instruction is discarded; any half-issued sequence is dropped.
      w_next_state = ST_NORMAL;
    end else if (stall) begin
      w_next_bubble = 1'b1;
      w_freeze      = 1'b1;
    end else begin
      case (r_state)
        ST_CALL2: begin
          w_next_op    = OP_CALL2;
          w_next_instr = r_saved;
          w_freeze     = 1'b1;
          w_next_state = ST_NORMAL;
        end
        ST_RET2: begin
          w_next_op    = OP_RET2;
          w_next_instr = r_saved;
          w_freeze     = 1'b1;
          w_next_state = ST_NORMAL;
        end
        ST_RTI2: begin
          w_next_op    = OP_RTI2;
          w_next_instr = r_saved;
          w_freeze     = 1'b1;
          w_next_state = ST_NORMAL;
        end
        ST_INT2: begin
          w_next_op    = OP_INT2;
          w_freeze     = 1'b1;
          w_next_state = ST_NORMAL;
        end
        default: begin
          if (r_int_pending) begin
            // Fetched word is held and replayed after the entry sequence.
            w_next_op    = OP_INT1;
            w_clear_int  = 1'b1;
            w_freeze     = 1'b1;
            w_next_state = ST_INT2;
          end else if (fetchedValid) begin
            if (is_internal_op(w_fetched_op)) begin
              w_next_op = OP_NOP;
            end else begin
              w_next_op    = w_fetched_op;
              w_next_instr = w_fetched_fields;
              case (w_fetched_op)
                OP_CALL: begin
                  w_next_saved = w_fetched_fields;
                  w_next_state = ST_CALL2;
                end
                OP_RET: begin
                  w_next_saved = w_fetched_fields;
                  w_next_state = ST_RET2;
                end
                OP_RTI: begin
                  w_next_saved = w_fetched_fields;
                  w_next_state = ST_RTI2;
                end
                default: w_next_state = ST_NORMAL;
              endcase
            end
          end
        end
      endcase
    end
  end

  // Register state, saved operand fields and the control-unit outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      r_state   <= ST_NORMAL;
      r_saved   <= 11'd0;
      r_op_code <= OP_NOP;
      r_bubble  <= 1'b0;
      r_instr   <= 11'd0;
    end else begin
      r_state   <= w_next_state;
      r_saved   <= w_next_saved;
      r_op_code <= w_next_op;
      r_bubble  <= w_next_bubble;
      r_instr   <= w_next_instr;
    end
  end

  // Interrupt request latch; a new request wins over the clear on take.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_int_pending <= 1'b0;
    end else if (interrupt) begin
      r_int_pending <= 1'b1;
    end else if (w_clear_int) begin
      r_int_pending <= 1'b0;
    end
  end

  assign freezePC     = w_freeze & ~rst;
  assign opCode       = r_op_code;
  assign makeMeBubble = r_bubble;
  assign instrOut     = r_instr;

endmodule

// File: tb/tb_opcode_sequencer.sv
// Self-checking bench for opcode_sequencer. Each scenario task builds a table
// of per-cycle stimulus plus expected results; expectations are queued when a
// row is driven and popped once the registered outputs have updated.
module tb_opcode_sequencer;
  import opcode_sequencer_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] fetchedInstr;
  logic        fetchedValid;
  logic        interrupt;
  logic        stall;
  logic        flush;
  logic [4:0]  opCode;
  logic        makeMeBubble;
  logic [10:0] instrOut;
  logic        freezePC;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        rst;
    logic        vld;
    logic [15:0] ins;
    logic        irq;
    logic        stl;
    logic        fls;
    logic        fz;    // expected freezePC during the cycle
    logic [4:0]  op;    // expected opCode after the edge
    logic        bub;   // expected makeMeBubble after the edge
    logic [10:0] oi;    // expected instrOut after the edge
    logic        oichk; // instrOut is checked only when set
    logic [2:0]  st;    // expected state after the edge
    logic        pd;    // expected intPending after the edge
  } row_t;

  row_t sb[$];

  opcode_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .fetchedInstr (fetchedInstr),
    .fetchedValid (fetchedValid),
    .interrupt    (interrupt),
    .stall        (stall),
    .flush        (flush),
    .opCode       (opCode),
    .makeMeBubble (makeMeBubble),
    .instrOut     (instrOut),
    .freezePC     (freezePC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic row_t mk(input logic r, input logic v, input logic [15:0] ins,
                              input logic irq, input logic s, input logic f,
                              input logic fz, input logic [4:0] op, input logic bub,
                              input logic [10:0] oi, input logic oichk,
                              input logic [2:0] st, input logic pd);
    row_t x;
    x.rst = r; x.vld = v; x.ins = ins; x.irq = irq; x.stl = s; x.fls = f;
    x.fz = fz; x.op = op; x.bub = bub; x.oi = oi; x.oichk = oichk;
    x.st = st; x.pd = pd;
    return x;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, settle to mid-cycle.
  task automatic apply(input row_t r);
    rst = r.rst; fetchedValid = r.vld; fetchedInstr = r.ins;
    interrupt = r.irq; stall = r.stl; flush = r.fls;
    sb.push_back(r);
    @(negedge clk);
  endtask

  task automatic test_reset();
    row_t rows[$]; row_t e;
    rows.push_back(mk(1,1,16'h4800,1,1,0, 0, OP_NOP,0,11'h000,1, ST_NORMAL,0));
    rows.push_back(mk(1,1,16'hC005,1,0,0, 0, OP_NOP,0,11'h000,1, ST_NORMAL,0));
    foreach (rows[i]) begin
      apply(rows[i]);
      n_tests++; if (freezePC !== rows[i].fz) begin n_fail++; $display("FAIL reset[%0d] freezePC got %b want %b", i, freezePC, rows[i].fz); end
      @(posedge clk); #1; e = sb.pop_front();
      n_tests++; if ({opCode, makeMeBubble} !== {e.op, e.bub}) begin n_fail++; $display("FAIL reset[%0d] op/bubble got %b/%b want %b/%b", i, opCode, makeMeBubble, e.op, e.bub); end
      if (e.oichk) begin n_tests++; if (instrOut !== e.oi) begin n_fail++; $display("FAIL reset[%0d] instrOut got %h want %h", i, instrOut, e.oi); end end
      n_tests++; if ({dut.r_state, dut.r_int_pending} !== {e.st, e.pd}) begin n_fail++; $display("FAIL reset[%0d] state/pending got %0d/%b want %0d/%b", i, dut.r_state, dut.r_int_pending, e.st, e.pd); end
    end
  endtask

  task automatic test_call();
    row_t rows[$]; row_t e;
    rows.push_back(mk(0,1,16'hC005,0,0,0, 0, OP_CALL, 0,11'h000,0, ST_CALL2, 0));
    rows.push_back(mk(0,1,16'h4800,0,0,0, 1, OP_CALL2,0,11'h005,1, ST_NORMAL,0));
    rows.push_back(mk(0,1,16'h4800,0,0,0, 0, 5'b01001,0,11'h000,1, ST_NORMAL,0));
    rows.push_back(mk(0,0,16'h4800,0,0,0, 0, OP_NOP,  0,11'h000,0, ST_NORMAL,0));
    rows.push_back(mk(0,1,16'hC8AB,0,0,0, 0, OP_NOP,  0,11'h000,0, ST_NORMAL,0));
    rows.push_back(mk(0,1,16'hFFFF,0,0,0, 0, OP_NOP,  0,11'h000,0, ST_NORMAL,0));
    rows.push_back(mk(0,1,16'h2ABC,0,0,0, 0, 5'b00101,0,11'h2BC,1, ST_NORMAL,0));
    foreach (rows[i]) begin
      apply(rows[i]);
      n_tests++; if (freezePC !== rows[i].fz) begin n_fail++; $display("FAIL call[%0d] freezePC got %b want %b", i, freezePC, rows[i].fz); end
      @(posedge clk); #1; e = sb.pop_front();
      n_tests++; if ({opCode, makeMeBubble} !== {e.op, e.bub}) begin n_fail++; $display("FAIL call[%0d] op/bubble got %b/%b want %b/%b", i, opCode, makeMeBubble, e.op, e.bub); end
      if (e.oichk) begin n_tests++; if (instrOut !== e.oi) begin n_fail++; $display("FAIL call[%0d] instrOut got %h want %h", i, instrOut, e.oi); end end
      n_tests++; if ({dut.r_state, dut.r_int_pending} !== {e.st, e.pd}) begin n_fail++; $display("FAIL call[%0d] state/pending got %0d/%b want %0d/%b", i, dut.r_state, dut.r_int_pending, e.st, e.pd); end
    end
  endtask

  task automatic test_interrupt();
    row_t rows[$]; row_t e;
    // Pulse lands while 0x4800 is consumed; entry sequence follows, then replay.
    rows.push_back(mk(0,1,16'h4800,1,0,0, 0, 5'b01001,0,11'h000,1, ST_NORMAL,1));
    rows.push_back(mk(0,1,16'h4800,0,0,0, 1, OP_INT1, 0,11'h000,0, ST_INT2,  0));
    rows.push_back(mk(0,1,16'h4800,0,0,0, 1, OP_INT2, 0,11'h000,0, ST_NORMAL,0));
    rows.push_back(mk(0,1,16'h4800,0,0,0, 0, 5'b01001,0,11'h000,1, ST_NORMAL,0));
    foreach (rows[i]) begin
      apply(rows[i]);
      n_tests++; if (freezePC !== rows[i].fz) begin n_fail++; $display("FAIL irq[%0d] freezePC got %b want %b", i, freezePC, rows[i].fz); end
      @(posedge clk); #1; e = sb.pop_front();
      n_tests++; if ({opCode, makeMeBubble} !== {e.op, e.bub}) begin n_fail++; $display("FAIL irq[%0d] op/bubble got %b/%b want %b/%b", i, opCode, makeMeBubble, e.op, e.bub); end
      if (e.oichk) begin n_tests++; if (instrOut !== e.oi) begin n_fail++; $display("FAIL irq[%0d] instrOut got %h want %h", i, instrOut, e.oi); end end
      n_tests++; if ({dut.r_state, dut.r_int_pending} !== {e.st, e.pd}) begin n_fail++; $display("FAIL irq[%0d] state/pending got %0d/%b want %0d/%b", i, dut.r_state, dut.r_int_pending, e.st, e.pd); end
    end
  endtask

  task automatic test_deferred_irq();
    row_t rows[$]; row_t e;
    // Interrupt during RET2 waits for NORMAL.
    rows.push_back(mk(0,1,16'hD123,0,0,0, 0, OP_RET,  0,11'h000,0, ST_RET2,  0));
    rows.push_back(mk(0,1,16'h4800,1,0,0, 1, OP_RET2, 0,11'h123,1, ST_NORMAL,1));
    rows.push_back(mk(0,1,16'h4800,0,0,0, 1, OP_INT1, 0,11'h000,0, ST_INT2,  0));
    rows.push_back(mk(0,1,16'h4800,0,0,0, 1, OP_INT2, 0,11'h000,0, ST_NORMAL,0));
    rows.push_back(mk(0,1,16'h4800,0,0,0, 0, 5'b01001,0,11'h000,1, ST_NORMAL,0));
    // A new request in the cycle the pending one is taken stays pending.
    rows.push_back(mk(0,1,16'h4800,1,0,0, 0, 5'b01001,0,11'h000,1, ST_NORMAL,1));
    rows.push_back(mk(0,1,16'h4800,1,0,0, 1, OP_INT1, 0,11'h000,0, ST_INT2,  1));
    rows.push_back(mk(0,1,16'h4800,0,0,0, 1, OP_INT2, 0,11'h000,0, ST_NORMAL,1));
    rows.push_back(mk(0,1,16'h4800,0,0,0, 1, OP_INT1, 0,11'h000,0, ST_INT2,  0));
    rows.push_back(mk(0,1,16'h4800,0,0,0, 1, OP_INT2, 0,11'h000,0, ST_NORMAL,0));
    rows.push_back(mk(0,1,16'h4800,0,0,0, 0, 5'b01001,0,11'h000,1, ST_NORMAL,0));
    foreach (rows[i]) begin
      apply(rows[i]);
      n_tests++; if (freezePC !== rows[i].fz) begin n_fail++; $display("FAIL defer[%0d] freezePC got %b want %b", i, freezePC, rows[i].fz); end
      @(posedge clk); #1; e = sb.pop_front();
      n_tests++; if ({opCode, makeMeBubble} !== {e.op, e.bub}) begin n_fail++; $display("FAIL defer[%0d] op/bubble got %b/%b want %b/%b", i, opCode, makeMeBubble, e.op, e.bub); end
      if (e.oichk) begin n_tests++; if (instrOut !== e.oi) begin n_fail++; $display("FAIL defer[%0d] instrOut got %h want %h", i, instrOut, e.oi); end end
      n_tests++; if ({dut.r_state, dut.r_int_pending} !== {e.st, e.pd}) begin n_fail++; $display("FAIL defer[%0d] state/pending got %0d/%b want %0d/%b", i, dut.r_state, dut.r_int_pending, e.st, e.pd); end
    end
  endtask

  task automatic test_stall();
    row_t rows[$]; row_t e;
    rows.push_back(mk(0,1,16'hE7FF,0,0,0, 0, OP_RTI,  0,11'h000,0, ST_RTI2,  0));
    rows.push_back(mk(0,1,16'h4800,0,1,0, 1, OP_NOP,  1,11'h000,0, ST_RTI2,  0));
    rows.push_back(mk(0,1,16'h4800,0,1,0, 1, OP_NOP,  1,11'h000,0, ST_RTI2,  0));
    rows.push_back(mk(0,1,16'h4800,0,0,0, 1, OP_RTI2, 0,11'h7FF,1, ST_NORMAL,0));
    rows.push_back(mk(0,1,16'h4800,0,0,0, 0, 5'b01001,0,11'h000,1, ST_NORMAL,0));
    foreach (rows[i]) begin
      apply(rows[i]);
      n_tests++; if (freezePC !== rows[i].fz) begin n_fail++; $display("FAIL stall[%0d] freezePC got %b want %b", i, freezePC, rows[i].fz); end
      @(posedge clk); #1; e = sb.pop_front();
      n_tests++; if ({opCode, makeMeBubble} !== {e.op, e.bub}) begin n_fail++; $display("FAIL stall[%0d] op/bubble got %b/%b want %b/%b", i, opCode, makeMeBubble, e.op, e.bub); end
      if (e.oichk) begin n_tests++; if (instrOut !== e.oi) begin n_fail++; $display("FAIL stall[%0d] instrOut got %h want %h", i, instrOut, e.oi); end end
      n_tests++; if ({dut.r_state, dut.r_int_pending} !== {e.st, e.pd}) begin n_fail++; $display("FAIL stall[%0d] state/pending got %0d/%b want %0d/%b", i, dut.r_state, dut.r_int_pending, e.st, e.pd); end
    end
  endtask

  task automatic test_flush();
    row_t rows[$]; row_t e;
    // Interrupt latched in the CALL cycle; flush (with stall) hits CALL2.
    rows.push_back(mk(0,1,16'hC005,1,0,0, 0, OP_CALL, 0,11'h000,0, ST_CALL2, 1));
    rows.push_back(mk(0,1,16'h4800,0,1,1, 0, OP_NOP,  0,11'h000,0, ST_NORMAL,1));
    rows.push_back(mk(0,1,16'h4800,0,0,0, 1, OP_INT1, 0,11'h000,0, ST_INT2,  0));
    rows.push_back(mk(0,1,16'h4800,0,0,0, 1, OP_INT2, 0,11'h000,0, ST_NORMAL,0));
    rows.push_back(mk(0,1,16'h4800,0,0,0, 0, 5'b01001,0,11'h000,1, ST_NORMAL,0));
    foreach (rows[i]) begin
      apply(rows[i]);
      n_tests++; if (freezePC !== rows[i].fz) begin n_fail++; $display("FAIL flush[%0d] freezePC got %b want %b", i, freezePC, rows[i].fz); end
      @(posedge clk); #1; e = sb.pop_front();
      n_tests++; if ({opCode, makeMeBubble} !== {e.op, e.bub}) begin n_fail++; $display("FAIL flush[%0d] op/bubble got %b/%b want %b/%b", i, opCode, makeMeBubble, e.op, e.bub); end
      if (e.oichk) begin n_tests++; if (instrOut !== e.oi) begin n_fail++; $display("FAIL flush[%0d] instrOut got %h want %h", i, instrOut, e.oi); end end
      n_tests++; if ({dut.r_state, dut.r_int_pending} !== {e.st, e.pd}) begin n_fail++; $display("FAIL flush[%0d] state/pending got %0d/%b want %0d/%b", i, dut.r_state, dut.r_int_pending, e.st, e.pd); end
    end
  endtask

  task automatic test_reset_midseq();
    row_t rows[$]; row_t e;
    rows.push_back(mk(0,1,16'h4800,1,0,0, 0, 5'b01001,0,11'h000,1, ST_NORMAL,1));
    rows.push_back(mk(0,1,16'h4800,0,0,0, 1, OP_INT1, 0,11'h000,0, ST_INT2,  0));
    rows.push_back(mk(1,1,16'h4800,1,0,0, 0, OP_NOP,  0,11'h000,1, ST_NORMAL,0));
    rows.push_back(mk(0,1,16'h4800,0,0,0, 0, 5'b01001,0,11'h000,1, ST_NORMAL,0));
    rows.push_back(mk(0,1,16'h2ABC,0,0,0, 0, 5'b00101,0,11'h2BC,1, ST_NORMAL,0));
    foreach (rows[i]) begin
      apply(rows[i]);
      n_tests++; if (freezePC !== rows[i].fz) begin n_fail++; $display("FAIL rstmid[%0d] freezePC got %b want %b", i, freezePC, rows[i].fz); end
      @(posedge clk); #1; e = sb.pop_front();
      n_tests++; if ({opCode, makeMeBubble} !== {e.op, e.bub}) begin n_fail++; $display("FAIL rstmid[%0d] op/bubble got %b/%b want %b/%b", i, opCode, makeMeBubble, e.op, e.bub); end
      if (e.oichk) begin n_tests++; if (instrOut !== e.oi) begin n_fail++; $display("FAIL rstmid[%0d] instrOut got %h want %h", i, instrOut, e.oi); end end
      n_tests++; if ({dut.r_state, dut.r_int_pending} !== {e.st, e.pd}) begin n_fail++; $display("FAIL rstmid[%0d] state/pending got %0d/%b want %0d/%b", i, dut.r_state, dut.r_int_pending, e.st, e.pd); end
    end
  endtask

  initial begin
    rst = 1'b1; fetchedInstr = 16'h0000; fetchedValid = 1'b0;
    interrupt = 1'b0; stall = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_call();
    test_interrupt();
    test_deferred_irq();
    test_stall();
    test_flush();
    test_reset_midseq();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
